// File: rtl/snake_rom_arbiter.sv
// Shares one snake sprite ROM port between the green and red renderers.
// Per-cycle arbitration, pipelined lookup, fixed grant-to-valid latency.
module snake_rom_arbiter #(
    parameter int          ROM_LAT     = 0,
    parameter logic [23:0] TRANSPARENT = 24'h000000,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_g_req,
    input  logic [3:0]  i_g_image,
    input  logic [9:0]  i_g_pos_x,
    input  logic [9:0]  i_g_pos_y,
    output logic        o_g_gnt,
    output logic        o_g_valid,
    output logic [23:0] o_g_data,
    input  logic        i_r_req,
    input  logic [3:0]  i_r_image,
    input  logic [9:0]  i_r_pos_x,
    input  logic [9:0]  i_r_pos_y,
    output logic        o_r_gnt,
    output logic        o_r_valid,
    output logic [23:0] o_r_data,
    output logic        o_rom_sel,
    output logic [3:0]  o_rom_image,
    output logic [9:0]  o_rom_pos_x,
    output logic [9:0]  o_rom_pos_y,
    input  logic [23:0] i_rom_data
);

    // Tag fields: [2] valid, [1] sel (1 = red), [0] illegal image
    logic        r_rr_red;
    logic [2:0]  r_tag [0:ROM_LAT];
    logic        w_g_gnt;
    logic        w_r_gnt;
    logic        w_any;
    logic [3:0]  w_image;
    logic [9:0]  w_pos_x;
    logic [9:0]  w_pos_y;
    logic [2:0]  w_cap;
    logic [23:0] w_pix;

    always_comb begin
        w_g_gnt = 1'b0;
        w_r_gnt = 1'b0;
        if (!i_rst) begin
            if (i_g_req && (!i_r_req || FIXED_PRIO || !r_rr_red)) begin
                w_g_gnt = 1'b1;
            end else if (i_r_req) begin
                w_r_gnt = 1'b1;
            end
        end
    end

    assign o_g_gnt = w_g_gnt;
    assign o_r_gnt = w_r_gnt;
    assign w_any   = w_g_gnt | w_r_gnt;
    assign w_image = w_r_gnt ? i_r_image : i_g_image;
    assign w_pos_x = w_r_gnt ? i_r_pos_x : i_g_pos_x;
    assign w_pos_y = w_r_gnt ? i_r_pos_y : i_g_pos_y;
    assign w_cap   = r_tag[ROM_LAT];
    assign w_pix   = w_cap[0] ? TRANSPARENT : i_rom_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_red    <= 1'b0;
            o_rom_sel   <= 1'b0;
            o_rom_image <= 4'd0;
            o_rom_pos_x <= 10'd0;
            o_rom_pos_y <= 10'd0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_tag[i] <= 3'b000;
            end
            o_g_valid   <= 1'b0;
            o_r_valid   <= 1'b0;
            o_g_data    <= 24'd0;
            o_r_data    <= 24'd0;
        end else begin
            if (w_any) begin
                r_rr_red    <= w_g_gnt;
                o_rom_sel   <= w_r_gnt;
                o_rom_image <= w_image;
                o_rom_pos_x <= w_pos_x;
                o_rom_pos_y <= w_pos_y;
            end
            r_tag[0] <= {w_any, w_r_gnt, w_any && (w_image >= 4'd14)};
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            o_g_valid <= w_cap[2] && !w_cap[1];
            o_r_valid <= w_cap[2] && w_cap[1];
            if (w_cap[2] && !w_cap[1]) begin
                o_g_data <= w_pix;
            end
            if (w_cap[2] && w_cap[1]) begin
                o_r_data <= w_pix;
            end
        end
    end

endmodule
